// File: rtl/horner_coeff_seq_if.sv
// Sequencer-side bus: coefficient table writes, run control and the
// evaluator x/coefficient stream with its returned result.
interface horner_coeff_seq_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [AW-1:0] deg;
  logic [W-1:0]  x_in;
  logic          start;
  logic          busy;
  logic [W-1:0]  x_out;
  logic [W-1:0]  cn_out;
  logic          cn_valid;
  logic          cn_first;
  logic [W-1:0]  z_in;
  logic [W-1:0]  result;
  logic          done;

  modport slave (
    input  wr_en, wr_addr, wr_data, deg, x_in, start, z_in,
    output busy, x_out, cn_out, cn_valid, cn_first, result, done
  );

  modport master (
    output wr_en, wr_addr, wr_data, deg, x_in, start, z_in,
    input  busy, x_out, cn_out, cn_valid, cn_first, result, done
  );
endinterface

// File: rtl/horner_coeff_seq.sv
// Upstream sequencer for the Horner evaluator: streams x and the coefficients
// highest-degree-first, waits out the evaluator latency, then captures z.
module horner_coeff_seq #(
  parameter int unsigned W       = 32,
  parameter int unsigned MAX_DEG = 7,
  parameter int unsigned AW      = 3,
  parameter int unsigned ACC_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  horner_coeff_seq_if.slave bus
);

  localparam int unsigned LW        = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
  localparam logic [AW:0] DEG_LIMIT = (AW+1)'(MAX_DEG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        r_state, w_state_n;
  logic [AW-1:0] r_k, w_k_n;
  logic [LW-1:0] r_wcnt, w_wcnt_n;
  logic [W-1:0]  r_tab [MAX_DEG+1];
  logic [W-1:0]  r_x_out, w_x_out_n;
  logic [W-1:0]  r_cn_out, w_cn_out_n;
  logic          r_cn_valid, w_cn_valid_n;
  logic          r_cn_first, w_cn_first_n;
  logic          r_busy, w_busy_n;
  logic [W-1:0]  r_result, w_result_n;
  logic          r_done, w_done_n;

  logic          w_idle_like;
  logic          w_wr_ok;
  logic          w_start_ok;
  logic [AW-1:0] w_deg_sat;
  logic [AW-1:0] w_rd_idx;
  logic [W-1:0]  w_rd_data;

  // Table is writable and start is honoured only outside an active run
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_wr_ok     = bus.wr_en && w_idle_like && ({1'b0, bus.wr_addr} <= DEG_LIMIT);
  assign w_start_ok  = bus.start && w_idle_like;
  assign w_deg_sat   = ({1'b0, bus.deg} > DEG_LIMIT) ? AW'(MAX_DEG) : bus.deg;

  // Same-cycle write forwarding so a run launched with a write sees the new value
  assign w_rd_idx  = (r_state == S_ISSUE) ? AW'(r_k - AW'(1)) : w_deg_sat;
  assign w_rd_data = (w_wr_ok && (bus.wr_addr == w_rd_idx)) ? bus.wr_data : r_tab[w_rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(MAX_DEG) + 1; i++) begin
        r_tab[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_tab[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_wcnt     <= '0;
      r_x_out    <= '0;
      r_cn_out   <= '0;
      r_cn_valid <= 1'b0;
      r_cn_first <= 1'b0;
      r_busy     <= 1'b0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_k        <= w_k_n;
      r_wcnt     <= w_wcnt_n;
      r_x_out    <= w_x_out_n;
      r_cn_out   <= w_cn_out_n;
      r_cn_valid <= w_cn_valid_n;
      r_cn_first <= w_cn_first_n;
      r_busy     <= w_busy_n;
      r_result   <= w_result_n;
      r_done     <= w_done_n;
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_k_n        = r_k;
    w_wcnt_n     = r_wcnt;
    w_x_out_n    = r_x_out;
    w_cn_out_n   = r_cn_out;
    w_cn_valid_n = 1'b0;
    w_cn_first_n = 1'b0;
    w_busy_n     = r_busy;
    w_result_n   = r_result;
    w_done_n     = 1'b0;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_ok) begin
          w_state_n    = S_ISSUE;
          w_k_n        = w_deg_sat;
          w_x_out_n    = bus.x_in;
          w_cn_out_n   = w_rd_data;
          w_cn_valid_n = 1'b1;
          w_cn_first_n = 1'b1;
          w_busy_n     = 1'b1;
        end else begin
          w_state_n = S_IDLE;
          w_busy_n  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (r_k == '0) begin
          w_state_n = S_WAIT;
          w_wcnt_n  = LW'(ACC_LAT - 1);
        end else begin
          w_k_n        = AW'(r_k - AW'(1));
          w_cn_out_n   = w_rd_data;
          w_cn_valid_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_wcnt == '0) begin
          w_state_n  = S_DONE;
          w_result_n = bus.z_in;
          w_done_n   = 1'b1;
        end else begin
          w_wcnt_n = LW'(r_wcnt - LW'(1));
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = r_busy;
  assign bus.x_out    = r_x_out;
  assign bus.cn_out   = r_cn_out;
  assign bus.cn_valid = r_cn_valid;
  assign bus.cn_first = r_cn_first;
  assign bus.result   = r_result;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_horner_coeff_seq.sv
// Directed bench for horner_coeff_seq with a one-cycle Horner evaluator model,
// plus a second instance with MAX_DEG=5 to exercise degree saturation.
module tb_horner_coeff_seq;

  logic clk;
  logic rst;

  horner_coeff_seq_if #(.W(32), .AW(3)) bus  ();
  horner_coeff_seq_if #(.W(32), .AW(3)) bus2 ();

  horner_coeff_seq #(.W(32), .MAX_DEG(7), .AW(3), .ACC_LAT(1)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  horner_coeff_seq #(.W(32), .MAX_DEG(5), .AW(3), .ACC_LAT(1)) u_sat (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_tab [8];
  logic [31:0] acc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Evaluator model: acc = first ? c : acc*x + c, z valid one cycle later
  always @(posedge clk) begin
    if (bus.cn_valid) acc <= bus.cn_first ? bus.cn_out : acc * bus.x_out + bus.cn_out;
  end
  assign bus.z_in  = acc;
  assign bus2.z_in = 32'h0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    model_tab[a] = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  // One full run from IDLE; optional write alongside start, optional start/write poke mid-ISSUE
  task automatic do_run(input string tag, input logic [2:0] d, input logic [31:0] x,
                        input logic [31:0] exp_res, input bit poke, input bit wr_now,
                        input logic [2:0] wa, input logic [31:0] wd);
    int n;
    n = int'(d) + 1;
    bus.start = 1'b1; bus.deg = d; bus.x_in = x;
    if (wr_now) begin
      bus.wr_en = 1'b1; bus.wr_addr = wa; bus.wr_data = wd;
      model_tab[wa] = wd;
    end
    tick();
    bus.start = 1'b0; bus.wr_en = 1'b0;
    for (int j = 0; j < n; j++) begin
      chk($sformatf("%s cn_valid j=%0d", tag, j), 32'(bus.cn_valid), 32'd1);
      chk($sformatf("%s cn_first j=%0d", tag, j), 32'(bus.cn_first), (j == 0) ? 32'd1 : 32'd0);
      chk($sformatf("%s cn_out j=%0d", tag, j), bus.cn_out, model_tab[n-1-j]);
      chk($sformatf("%s x_out j=%0d", tag, j), bus.x_out, x);
      chk($sformatf("%s busy j=%0d", tag, j), 32'(bus.busy), 32'd1);
      if (poke && j == 1) begin
        bus.start = 1'b1; bus.deg = 3'd0;
        bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 32'hDEAD_BEEF;
      end
      if (poke && j == 3) begin
        bus.start = 1'b0; bus.wr_en = 1'b0;
      end
      tick();
    end
    chk({tag, " wait cn_valid"}, 32'(bus.cn_valid), 32'd0);
    chk({tag, " wait cn_out"}, bus.cn_out, model_tab[0]);
    chk({tag, " wait done"}, 32'(bus.done), 32'd0);
    tick();
    chk({tag, " done"}, 32'(bus.done), 32'd1);
    chk({tag, " result"}, bus.result, exp_res);
    chk({tag, " done busy"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, " post done"}, 32'(bus.done), 32'd0);
    chk({tag, " post busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " post result"}, bus.result, exp_res);
  endtask

  initial begin
    int          cnt;
    bit          seen_done;
    logic [31:0] first_val;

    rst = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.deg = 0; bus.x_in = 0; bus.start = 0;
    bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0; bus2.deg = 0; bus2.x_in = 0; bus2.start = 0;
    for (int i = 0; i < 8; i++) model_tab[i] = '0;

    // Reset with noisy start/write traffic
    for (int c = 0; c < 2; c++) begin
      bus.start = 1'($urandom); bus.wr_en = 1'b1;
      bus.wr_addr = 3'($urandom); bus.wr_data = $urandom; bus.x_in = $urandom; bus.deg = 3'($urandom);
      tick();
    end
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst cn_valid", 32'(bus.cn_valid), 32'd0);
    chk("rst cn_first", 32'(bus.cn_first), 32'd0);
    chk("rst result", bus.result, 32'd0);
    chk("rst x_out", bus.x_out, 32'd0);
    chk("rst cn_out", bus.cn_out, 32'd0);
    rst = 1'b1;
    bus.start = 1'b0; bus.wr_en = 1'b0;
    tick();

    do_run("zero_table", 3'd7, 32'd5, 32'd0, 1'b0, 1'b0, 3'd0, 32'd0);

    wr(3'd0, 32'd1); wr(3'd1, 32'd1); wr(3'd2, 32'd1);
    do_run("x2+x+1", 3'd2, 32'd2, 32'd7, 1'b0, 1'b0, 3'd0, 32'd0);

    wr(3'd0, 32'd5);
    do_run("const", 3'd0, 32'd2, 32'd5, 1'b0, 1'b0, 3'd0, 32'd0);

    // 4*9 + 1*3 + 5 with coef[2] written in the start cycle
    do_run("wr_at_start", 3'd2, 32'd3, 32'd44, 1'b0, 1'b1, 3'd2, 32'd4);

    for (int i = 0; i < 8; i++) wr(3'(i), 32'h10 + 32'(i));
    do_run("deg7_poke", 3'd7, 32'd1, 32'h9C, 1'b1, 1'b0, 3'd0, 32'd0);
    do_run("tab_after_poke", 3'd3, 32'd0, 32'h10, 1'b0, 1'b0, 3'd0, 32'd0);

    // Back-to-back: start held, second run accepted in the DONE cycle
    bus.start = 1'b1; bus.deg = 3'd1; bus.x_in = 32'd2;
    tick(); tick(); tick();
    chk("b2b wait cn_valid", 32'(bus.cn_valid), 32'd0);
    bus.x_in = 32'd3;
    tick();
    chk("b2b done1", 32'(bus.done), 32'd1);
    chk("b2b result1", bus.result, 32'h32);
    chk("b2b busy1", 32'(bus.busy), 32'd1);
    tick();
    bus.start = 1'b0;
    chk("b2b cn_first2", 32'(bus.cn_first), 32'd1);
    chk("b2b cn_valid2", 32'(bus.cn_valid), 32'd1);
    chk("b2b cn_out2", bus.cn_out, 32'h11);
    chk("b2b x_out2", bus.x_out, 32'd3);
    chk("b2b busy gap", 32'(bus.busy), 32'd1);
    chk("b2b done low", 32'(bus.done), 32'd0);
    tick(); tick(); tick();
    chk("b2b done2", 32'(bus.done), 32'd1);
    chk("b2b result2", bus.result, 32'h43);
    tick();

    // Abort during WAIT
    bus.start = 1'b1; bus.deg = 3'd2; bus.x_in = 32'd2;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    chk("abort in wait", 32'(bus.cn_valid), 32'd0);
    rst = 1'b0;
    tick();
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort result", bus.result, 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort x_out", bus.x_out, 32'd0);
    rst = 1'b1;
    tick();
    chk("abort no late done", 32'(bus.done), 32'd0);
    for (int i = 0; i < 8; i++) model_tab[i] = '0;
    wr(3'd0, 32'd1); wr(3'd1, 32'd1); wr(3'd2, 32'd1);
    do_run("after_abort", 3'd2, 32'd3, 32'd13, 1'b0, 1'b0, 3'd0, 32'd0);

    // deg=7 on a MAX_DEG=5 instance saturates to 6 coefficients
    bus2.wr_en = 1'b1; bus2.wr_addr = 3'd5; bus2.wr_data = 32'hAB;
    tick();
    bus2.wr_en = 1'b0;
    bus2.start = 1'b1; bus2.deg = 3'd7; bus2.x_in = 32'd0;
    tick();
    bus2.start = 1'b0;
    cnt = 0; seen_done = 1'b0; first_val = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus2.cn_valid) cnt++;
      if (bus2.cn_first) first_val = bus2.cn_out;
      if (bus2.done) seen_done = 1'b1;
      tick();
    end
    chk("sat coef count", 32'(cnt), 32'd6);
    chk("sat first coef", first_val, 32'hAB);
    chk("sat done seen", 32'(seen_done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
